// File: rtl/reader_pie_tx.sv
// reader_pie_tx: reader-side PIE transmitter (delimiter, preamble/frame-sync, MSB-first PIE data)
// Optional CRC-16 trailer enabled by defining PIE_TX_CRC16_EN.
module reader_pie_tx #(
  parameter int MAX_BITS = 128,
  parameter int LEN_W    = 8,
  parameter int DELIM    = 4,
  parameter int TARI     = 8,
  parameter int DATA1    = 14,
  parameter int PW       = 4,
  parameter int RTCAL    = 22,
  parameter int TRCAL    = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_preamble,
  input  logic [LEN_W-1:0]    i_len,
  input  logic [MAX_BITS-1:0] i_data,
`ifdef PIE_TX_CRC16_EN
  input  logic                i_crc_en,
`endif
  output logic                o_pie,
  output logic                o_busy,
  output logic                o_done
);
  localparam int CW = $clog2(TRCAL + 1);
  typedef enum logic [2:0] {S_IDLE, S_DELIM, S_D0, S_RTCAL, S_TRCAL, S_DATA, S_CRC, S_DONE} state_t;
  state_t              st, st_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [MAX_BITS-1:0] sh, sh_n;
  logic [LEN_W-1:0]    bits, bits_n;
  logic                pre, pre_n, pie_n, busy_n, done_n;
  logic                fin, data_go, data_end, shift;
`ifdef PIE_TX_CRC16_EN
  logic [15:0]         crc, crc_n;
  logic                ce, ce_n;
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
`endif
  function automatic logic [CW-1:0] sym(input logic b);
    return b ? CW'(DATA1) : CW'(TARI);
  endfunction
  // cnt holds cycles left in the current symbol, so the low pulse is simply cnt <= PW
  assign fin      = cnt == CW'(1);
  assign data_go  = fin && ((st == S_RTCAL && !pre) || st == S_TRCAL);
  assign shift    = fin && (st == S_DATA || st == S_CRC) && bits != LEN_W'(1);
  assign data_end = (data_go && bits == '0) || (fin && st == S_DATA && bits == LEN_W'(1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= S_IDLE;
      cnt    <= '0;
      sh     <= '0;
      bits   <= '0;
      pre    <= 1'b0;
      o_pie  <= 1'b1;
      o_busy <= 1'b0;
      o_done <= 1'b0;
`ifdef PIE_TX_CRC16_EN
      crc    <= 16'hFFFF;
      ce     <= 1'b0;
`endif
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      bits   <= bits_n;
      pre    <= pre_n;
      o_pie  <= pie_n;
      o_busy <= busy_n;
      o_done <= done_n;
`ifdef PIE_TX_CRC16_EN
      crc    <= crc_n;
      ce     <= ce_n;
`endif
    end
  end
  always_comb begin
    st_n   = st;
    cnt_n  = cnt - CW'(1);
    sh_n   = sh;
    bits_n = bits;
    pre_n  = pre;
`ifdef PIE_TX_CRC16_EN
    crc_n  = crc;
    ce_n   = ce;
`endif
    case (st)
      S_IDLE: begin
        cnt_n = cnt;
        if (i_start) begin
          st_n   = S_DELIM;
          cnt_n  = CW'(DELIM);
          sh_n   = i_data;
          bits_n = (i_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : i_len;
          pre_n  = i_preamble;
`ifdef PIE_TX_CRC16_EN
          crc_n  = 16'hFFFF;
          ce_n   = i_crc_en;
`endif
        end
      end
      S_DELIM: if (fin) begin st_n = S_D0; cnt_n = CW'(TARI); end
      S_D0:    if (fin) begin st_n = S_RTCAL; cnt_n = CW'(RTCAL); end
      S_RTCAL: if (fin && pre) begin st_n = S_TRCAL; cnt_n = CW'(TRCAL); end
      S_DONE:  begin st_n = S_IDLE; cnt_n = cnt; end
      default: ;
    endcase
    if (data_go && bits != '0) begin
      st_n  = S_DATA;
      cnt_n = sym(sh[MAX_BITS-1]);
`ifdef PIE_TX_CRC16_EN
      crc_n = crc_upd(crc, sh[MAX_BITS-1]);
`endif
    end
    if (shift) begin
      sh_n   = sh << 1;
      bits_n = bits - LEN_W'(1);
      cnt_n  = sym(sh[MAX_BITS-2]);
`ifdef PIE_TX_CRC16_EN
      if (st == S_DATA) crc_n = crc_upd(crc, sh[MAX_BITS-2]);
`endif
    end
    // CRC already covers every payload bit here since it is folded in as each bit is loaded
    if (data_end) begin
`ifdef PIE_TX_CRC16_EN
      if (ce) begin
        st_n   = S_CRC;
        bits_n = LEN_W'(16);
        sh_n   = {~crc, {(MAX_BITS-16){1'b0}}};
        cnt_n  = sym(~crc[15]);
      end else st_n = S_DONE;
`else
      st_n = S_DONE;
`endif
    end
    if (fin && st == S_CRC && bits == LEN_W'(1)) st_n = S_DONE;
  end
  always_comb begin
    pie_n  = (st_n == S_DELIM) ? 1'b0 : (st_n == S_IDLE || st_n == S_DONE) ? 1'b1 : (cnt_n > CW'(PW));
    busy_n = !(st_n == S_IDLE || st_n == S_DONE);
    done_n = st_n == S_DONE;
  end
endmodule
